// File: rtl/rv32im_bus_pkg.sv
// Shared types and constants for the rv32im Wishbone arbiter.
// Used by rv32im_bus_arbiter (RV32IM_ARB_ROUND_ROBIN_EN selects its policy).
package rv32im_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int unsigned BUS_MEMORY   = 0;
  localparam int unsigned BUS_PREFETCH = 1;
  localparam int unsigned BUS_EXTERNAL = 2;

  localparam int unsigned SEL_W = 4;

  // Index following idx, wrapping at n.
  function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rv32im_priority_pick.sv
// Combinational one-hot picker: first set request found scanning upward
// (with wrap) from the starting index wins.
module rv32im_priority_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'((32'(start) + k) % N);
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32im_bus_arbiter.sv
// Wishbone arbiter / master mux sharing one bus between NUM_MASTERS requesters.
// Define RV32IM_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority.
module rv32im_bus_arbiter
  import rv32im_bus_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_MASTERS = 3
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_MASTERS-1:0]          req_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*SEL_W-1:0]    m_sel_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [XLEN-1:0]                 m_dat_o,
  output logic [XLEN-3:0]                 adr_o,
  output logic [XLEN-1:0]                 dat_o,
  output logic [SEL_W-1:0]                sel_o,
  output logic                            cyc_o,
  output logic                            stb_o,
  output logic                            we_o,
  input  logic [XLEN-1:0]                 dat_i,
  input  logic                            ack_i,
  input  logic                            err_i
);

  localparam int unsigned AW    = XLEN - 2;
  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] winner;
  logic [IDX_W-1:0]       start_idx;

`ifdef RV32IM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] winner_idx;

  assign start_idx = IDX_W'(next_index(32'(ptr_q), NUM_MASTERS));

  always_comb begin
    winner_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (winner[i]) winner_idx = IDX_W'(i);
    end
  end

  // Pointer resets to the last index so requester 0 wins first.
  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= IDX_W'(NUM_MASTERS - 1);
    else         ptr_q <= ptr_d;
  end
`else
  assign start_idx = IDX_W'(BUS_MEMORY);
`endif

  rv32im_priority_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_i),
    .start  (start_idx),
    .onehot (winner)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_d = winner;
          state_d = OWNED;
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
          ptr_d   = winner_idx;
`endif
        end
      end
      OWNED: begin
        if (!(|(grant_q & (req_i | m_cyc_i)))) begin
          grant_d = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Grant is one-hot or zero, so an OR of gated slices acts as the mux.
  always_comb begin
    adr_o = '0;
    dat_o = '0;
    sel_o = '0;
    cyc_o = 1'b0;
    stb_o = 1'b0;
    we_o  = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        adr_o = adr_o | m_adr_i[i*AW +: AW];
        dat_o = dat_o | m_dat_i[i*XLEN +: XLEN];
        sel_o = sel_o | m_sel_i[i*SEL_W +: SEL_W];
        cyc_o = cyc_o | m_cyc_i[i];
        stb_o = stb_o | m_stb_i[i];
        we_o  = we_o  | m_we_i[i];
      end
    end
  end

  assign grant_o = grant_q;
  assign m_ack_o = {NUM_MASTERS{ack_i}} & grant_q;
  assign m_err_o = {NUM_MASTERS{err_i}} & grant_q;
  assign m_dat_o = dat_i;

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Randomized self-checking bench for rv32im_bus_arbiter against an owner/gap model;
// policy follows RV32IM_ARB_ROUND_ROBIN_EN as the design does.
module tb_rv32im_bus_arbiter;

  localparam int XLEN = 32;
  localparam int N    = 3;
  localparam int AW   = XLEN - 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req, cyc, stb, we;
  logic [N*AW-1:0]   m_adr;
  logic [N*XLEN-1:0] m_dat;
  logic [N*4-1:0]    m_sel;
  logic [XLEN-1:0]   dat_in;
  logic              ack, err;

  logic [N-1:0]      grant, m_ack, m_err;
  logic [XLEN-1:0]   m_dat_out, dat_out;
  logic [AW-1:0]     adr_out;
  logic [3:0]        sel_out;
  logic              cyc_out, stb_out, we_out;

  int errors = 0;
  int checks = 0;

  // Model: owner index (-1 = none), gap = in the dead cycle after a tenure.
  int owner = -1;
  int gap   = 0;
  int last  = N - 1;
  int held  = 0;

  always #5 clk = ~clk;

  rv32im_bus_arbiter #(
    .XLEN        (XLEN),
    .NUM_MASTERS (N)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   (req),
    .grant_o (grant),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_cyc_i (cyc),
    .m_stb_i (stb),
    .m_we_i  (we),
    .m_ack_o (m_ack),
    .m_err_o (m_err),
    .m_dat_o (m_dat_out),
    .adr_o   (adr_out),
    .dat_o   (dat_out),
    .sel_o   (sel_out),
    .cyc_o   (cyc_out),
    .stb_o   (stb_out),
    .we_o    (we_out),
    .dat_i   (dat_in),
    .ack_i   (ack),
    .err_i   (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (req[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic step();
    logic [63:0] e_adr, e_dat, e_sel, e_cyc, e_stb, e_we, e_gnt;
    @(posedge clk);
    if (reset) begin
      owner = -1; gap = 0; last = N - 1; held = 0;
    end else if (owner >= 0) begin
      if (!(req[owner] || cyc[owner])) begin
        owner = -1; gap = 1;
      end else begin
        held++;
      end
    end else if (gap != 0) begin
      gap = 0;
    end else if (req != 0) begin
      owner = pick(); last = owner; held = 1;
    end
    #1;
    if (owner >= 0) begin
      e_gnt = 64'(1) << owner;
      e_adr = 64'(m_adr[owner*AW +: AW]);
      e_dat = 64'(m_dat[owner*XLEN +: XLEN]);
      e_sel = 64'(m_sel[owner*4 +: 4]);
      e_cyc = 64'(cyc[owner]);
      e_stb = 64'(stb[owner]);
      e_we  = 64'(we[owner]);
    end else begin
      e_gnt = 0; e_adr = 0; e_dat = 0; e_sel = 0; e_cyc = 0; e_stb = 0; e_we = 0;
    end
    check("grant", 64'(grant), e_gnt);
    check("adr",   64'(adr_out), e_adr);
    check("dat",   64'(dat_out), e_dat);
    check("sel",   64'(sel_out), e_sel);
    check("cyc",   64'(cyc_out), e_cyc);
    check("stb",   64'(stb_out), e_stb);
    check("we",    64'(we_out),  e_we);
    check("ack",   64'(m_ack), ack ? e_gnt : 64'(0));
    check("err",   64'(m_err), err ? e_gnt : 64'(0));
    check("rdata", 64'(m_dat_out), 64'(dat_in));
  endtask

  task automatic rand_inputs();
    logic [95:0] r;
    req = 3'($urandom); cyc = 3'($urandom); stb = 3'($urandom); we = 3'($urandom);
    r = {$urandom, $urandom, $urandom}; m_adr = r[N*AW-1:0];
    m_dat = {$urandom, $urandom, $urandom};
    m_sel = 12'($urandom);
    dat_in = $urandom; ack = 1'($urandom); err = 1'($urandom);
    reset = ($urandom_range(0, 63) == 0);
  endtask

  logic [N-1:0] order[$];
  logic [N-1:0] prev_grant;

  initial begin
    reset = 1'b1; req = '1; cyc = '1; stb = '1; we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0; dat_in = '0; ack = 1'b0; err = 1'b0;

    // Reset held with everyone requesting
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_cyc",   64'(cyc_out), 64'(0));
      check("rst_stb",   64'(stb_out), 64'(0));
    end
    reset = 1'b0;
    step();
    check("first_grant", 64'(grant), 64'(3'b001));
    req = '0; cyc = '0; stb = '0;
    repeat (3) step();

    // Prefetch + external requesting from IDLE
    m_adr[0*AW +: AW] = 30'h111; m_adr[1*AW +: AW] = 30'h222; m_adr[2*AW +: AW] = 30'h333;
    req = 3'b110; cyc = 3'b110; stb = 3'b110;
    step();
    check("pf_grant", 64'(grant), 64'(3'b010));
    check("pf_adr",   64'(adr_out), 64'(30'h222));
    req = '0; cyc = '0; stb = '0;
    repeat (3) step();

    // Owner 0 keeps cyc with req low; ack routed only to it
    reset = 1'b1; step(); reset = 1'b0;
    req = 3'b001; cyc = 3'b001; stb = 3'b001;
    step();
    req = 3'b000; ack = 1'b1;
    step();
    check("hold_grant", 64'(grant), 64'(3'b001));
    check("hold_ack",   64'(m_ack), 64'(3'b001));
    ack = 1'b0;

    // Non-owner strobe and address must not reach the bus
    m_adr[0*AW +: AW] = 30'h0040; m_adr[2*AW +: AW] = 30'h3FFF;
    req = 3'b101; cyc = 3'b101; stb = 3'b101;
    step();
    check("own_adr", 64'(adr_out), 64'(30'h0040));
    check("own_stb", 64'(stb_out), 64'(1));
    stb = 3'b100;
    step();
    check("nonown_stb", 64'(stb_out), 64'(0));

    // Reset mid-write abandons the cycle
    req = 3'b001; cyc = 3'b001; stb = 3'b001; we = 3'b001;
    reset = 1'b1;
    step();
    check("rst_mid_cyc",   64'(cyc_out), 64'(0));
    check("rst_mid_stb",   64'(stb_out), 64'(0));
    check("rst_mid_we",    64'(we_out),  64'(0));
    check("rst_mid_grant", 64'(grant),   64'(0));
    reset = 1'b0; req = '0; cyc = '0; stb = '0; we = '0;
    step();

    // Everyone requesting, each tenure released after two cycles
    reset = 1'b1; step(); reset = 1'b0;
    prev_grant = '0;
    for (int c = 0; c < 24; c++) begin
      req = '1; cyc = '1;
      if (owner >= 0 && held >= 2) begin
        req[owner] = 1'b0; cyc[owner] = 1'b0;
      end
      step();
      if (prev_grant == '0 && grant != '0) order.push_back(grant);
      prev_grant = grant;
    end
    if (order.size() < 4) begin
      check("order_len", 64'(order.size()), 64'(4));
    end else begin
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
      check("order0", 64'(order[0]), 64'(3'b001));
      check("order1", 64'(order[1]), 64'(3'b010));
      check("order2", 64'(order[2]), 64'(3'b100));
      check("order3", 64'(order[3]), 64'(3'b001));
`else
      for (int i = 0; i < 4; i++) check("order_fixed", 64'(order[i]), 64'(3'b001));
`endif
    end

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
